// File: rtl/ws2812_receiver_if.sv
// Decoded-pixel output bundle of the WS2812 receiver.
// master = the receiver driving results, slave = the consumer.
interface ws2812_receiver_if #(
  parameter int unsigned IDX_W = 16
);
  logic [23:0]      pixel_data;
  logic             pixel_valid;
  logic [IDX_W-1:0] pixel_idx;
  logic             frame_done;
  logic [IDX_W-1:0] frame_len;
  logic             frame_active;
  logic             err;

  modport master (
    output pixel_data, pixel_valid, pixel_idx,
    output frame_done, frame_len, frame_active, err
  );

  modport slave (
    input pixel_data, pixel_valid, pixel_idx,
    input frame_done, frame_len, frame_active, err
  );
endinterface

// File: rtl/ws2812_receiver.sv
// WS2812 single-wire decoder: times high pulses into bits, packs them
// MSB-first into 24-bit pixels and detects the frame reset gap.
module ws2812_receiver #(
  parameter int unsigned T_THRESH   = 26,
  parameter int unsigned T_MIN_HIGH = 4,
  parameter int unsigned T_MAX_HIGH = 50,
  parameter int unsigned T_RESET    = 2500,
  parameter int unsigned IDX_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  ws2812_receiver_if.master  rx
);
  localparam int unsigned HW = $clog2(T_MAX_HIGH + 2);
  localparam int unsigned LW = $clog2(T_RESET + 1);

  localparam logic [HW-1:0] H_MIN = HW'(T_MIN_HIGH);
  localparam logic [HW-1:0] H_MAX = HW'(T_MAX_HIGH);
  localparam logic [HW-1:0] H_THR = HW'(T_THRESH);
  localparam logic [HW-1:0] H_SAT = HW'(T_MAX_HIGH + 1);
  localparam logic [LW-1:0] L_GAP = LW'(T_RESET);

  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;

  logic             s1_q, s2_q, dly_q;
  logic             rise_d, rise_q, fall_d, fall_q;
  logic [1:0]       state_d, state_q;
  logic [HW-1:0]    hcnt_d, hcnt_q;
  logic [LW-1:0]    lcnt_d, lcnt_q;
  logic [23:0]      shreg_d, shreg_q;
  logic [4:0]       bitcnt_d, bitcnt_q;
  logic [IDX_W-1:0] pixcnt_d, pixcnt_q;
  logic             got_d, got_q;
  logic [23:0]      pdata_d, pdata_q;
  logic             pvalid_d, pvalid_q;
  logic [IDX_W-1:0] pidx_d, pidx_q;
  logic             fdone_d, fdone_q;
  logic [IDX_W-1:0] flen_d, flen_q;
  logic             factive_d, factive_q;
  logic             err_d, err_q;

  always_comb begin
    // registered edge flags line up with dly_q, which is the level the counters use
    rise_d    = s2_q & ~dly_q;
    fall_d    = ~s2_q & dly_q;
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    pixcnt_d  = pixcnt_q;
    got_d     = got_q;
    pdata_d   = pdata_q;
    pvalid_d  = 1'b0;
    pidx_d    = pidx_q;
    fdone_d   = 1'b0;
    flen_d    = flen_q;
    factive_d = factive_q;
    err_d     = 1'b0;

    if (bitcnt_q == 5'd24) begin
      pdata_d  = shreg_q;
      pvalid_d = 1'b1;
      pidx_d   = pixcnt_q;
      pixcnt_d = pixcnt_q + 1'b1;
      bitcnt_d = '0;
    end

    case (state_q)
      SYNC: begin
        if (dly_q) begin
          lcnt_d = '0;
        end else if (lcnt_q == L_GAP - 1'b1) begin
          lcnt_d  = L_GAP;
          state_d = LOW;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      LOW: begin
        if (rise_q) begin
          state_d   = HIGH;
          hcnt_d    = HW'(1);
          factive_d = 1'b1;
        end else if (lcnt_q == L_GAP - 1'b1) begin
          // counter parks at L_GAP, so each gap reports at most once
          lcnt_d = L_GAP;
          if (got_q) begin
            fdone_d   = 1'b1;
            flen_d    = pixcnt_q;
            err_d     = (bitcnt_q != 5'd0);
            pixcnt_d  = '0;
            bitcnt_d  = '0;
            got_d     = 1'b0;
            factive_d = 1'b0;
          end
        end else if (lcnt_q != L_GAP) begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (fall_q) begin
          lcnt_d = LW'(1);
          if (hcnt_q < H_MIN || hcnt_q > H_MAX) begin
            err_d     = 1'b1;
            bitcnt_d  = '0;
            pixcnt_d  = '0;
            got_d     = 1'b0;
            factive_d = 1'b0;
            state_d   = SYNC;
          end else begin
            shreg_d  = {shreg_q[22:0], (hcnt_q >= H_THR)};
            bitcnt_d = bitcnt_q + 1'b1;
            got_d    = 1'b1;
            state_d  = LOW;
          end
        end else if (hcnt_q != H_SAT) begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      dly_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      state_q   <= SYNC;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      pixcnt_q  <= '0;
      got_q     <= 1'b0;
      pdata_q   <= '0;
      pvalid_q  <= 1'b0;
      pidx_q    <= '0;
      fdone_q   <= 1'b0;
      flen_q    <= '0;
      factive_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s1_q      <= din;
      s2_q      <= s1_q;
      dly_q     <= s2_q;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      pixcnt_q  <= pixcnt_d;
      got_q     <= got_d;
      pdata_q   <= pdata_d;
      pvalid_q  <= pvalid_d;
      pidx_q    <= pidx_d;
      fdone_q   <= fdone_d;
      flen_q    <= flen_d;
      factive_q <= factive_d;
      err_q     <= err_d;
    end
  end

  assign rx.pixel_data   = pdata_q;
  assign rx.pixel_valid  = pvalid_q;
  assign rx.pixel_idx    = pidx_q;
  assign rx.frame_done   = fdone_q;
  assign rx.frame_len    = flen_q;
  assign rx.frame_active = factive_q;
  assign rx.err          = err_q;
endmodule

// File: tb/tb_ws2812_receiver.sv
// Bench for ws2812_receiver: pulse-level reference model predicts pixels,
// frame ends and errors; a passive monitor records what the DUT emits.
module tb_ws2812_receiver;
  localparam int T_THRESH   = 26;
  localparam int T_MIN_HIGH = 4;
  localparam int T_MAX_HIGH = 50;
  localparam int T_RESET    = 2500;
  localparam int IDX_W      = 16;
  localparam int GAP        = 2600;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;

  ws2812_receiver_if #(.IDX_W(IDX_W)) rx ();

  ws2812_receiver #(
    .T_THRESH(T_THRESH), .T_MIN_HIGH(T_MIN_HIGH), .T_MAX_HIGH(T_MAX_HIGH),
    .T_RESET(T_RESET), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .rx(rx)
  );

  always #10 clk = ~clk;

  typedef struct { logic [23:0] data; int idx; int cyc; } px_t;
  typedef struct { int len; bit with_err; } fd_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap = 0;
  px_t exp_px[$], act_px[$];
  fd_t exp_fd[$], act_fd[$];
  int exp_err = 0, act_err = 0;

  // reference model state: pulse-level view of the stream
  bit          m_synced;
  int          m_low_run;
  int          m_nbits;
  logic [23:0] m_word;
  int          m_pix;
  bit          m_got;
  int          last_e0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rx.pixel_valid) act_px.push_back('{rx.pixel_data, int'(rx.pixel_idx), cyc});
    if (rx.frame_done) act_fd.push_back('{int'(rx.frame_len), bit'(rx.err)});
    if (rx.err) act_err++;
    if (rx.pixel_valid && rx.frame_done) overlap++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_synced = 0; m_low_run = 0; m_nbits = 0; m_word = '0; m_pix = 0; m_got = 0;
  endtask

  task automatic drive_high(input int h);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    last_e0 = cyc + 1;
    m_low_run = 0;
    if (m_synced) begin
      if (h < T_MIN_HIGH || h > T_MAX_HIGH) begin
        exp_err++;
        m_nbits = 0; m_pix = 0; m_got = 0; m_synced = 0;
      end else begin
        m_word = {m_word[22:0], (h >= T_THRESH)};
        m_nbits++;
        m_got = 1;
        if (m_nbits == 24) begin
          exp_px.push_back('{m_word, m_pix, last_e0 + 4});
          m_pix = (m_pix + 1) % (1 << IDX_W);
          m_nbits = 0;
        end
      end
    end
  endtask

  task automatic drive_low(input int l);
    int prev;
    repeat (l) @(negedge clk);
    prev = m_low_run;
    m_low_run += l;
    if (prev < T_RESET && m_low_run >= T_RESET) begin
      if (!m_synced) begin
        m_synced = 1;
      end else if (m_got) begin
        exp_fd.push_back('{m_pix, (m_nbits != 0)});
        if (m_nbits != 0) exp_err++;
        m_pix = 0; m_nbits = 0; m_got = 0;
      end
    end
  endtask

  task automatic send_bit(input bit b);
    drive_high(b ? int'($urandom_range(T_THRESH, T_MAX_HIGH))
                 : int'($urandom_range(T_MIN_HIGH, T_THRESH - 1)));
    drive_low(int'($urandom_range(4, 30)));
  endtask

  task automatic send_pixel(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_pixel_fixed(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) begin
      drive_high(w[i] ? 35 : 17);
      drive_low(w[i] ? 29 : 47);
    end
  endtask

  task automatic compare_all(input string tag);
    drive_low(8);
    chk({tag, "_px_count"}, act_px.size(), exp_px.size());
    for (int i = 0; i < act_px.size() && i < exp_px.size(); i++) begin
      chk($sformatf("%s_px%0d_data", tag, i), act_px[i].data, exp_px[i].data);
      chk($sformatf("%s_px%0d_idx", tag, i), act_px[i].idx, exp_px[i].idx);
      chk($sformatf("%s_px%0d_cyc", tag, i), act_px[i].cyc, exp_px[i].cyc);
    end
    chk({tag, "_fd_count"}, act_fd.size(), exp_fd.size());
    for (int i = 0; i < act_fd.size() && i < exp_fd.size(); i++) begin
      chk($sformatf("%s_fd%0d_len", tag, i), act_fd[i].len, exp_fd[i].len);
      chk($sformatf("%s_fd%0d_err", tag, i), act_fd[i].with_err, exp_fd[i].with_err);
    end
    chk({tag, "_err_count"}, act_err, exp_err);
    act_px.delete(); exp_px.delete(); act_fd.delete(); exp_fd.delete();
    act_err = 0; exp_err = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pixel_data"}, rx.pixel_data, 0);
    chk({tag, "_pixel_valid"}, rx.pixel_valid, 0);
    chk({tag, "_pixel_idx"}, rx.pixel_idx, 0);
    chk({tag, "_frame_done"}, rx.frame_done, 0);
    chk({tag, "_frame_len"}, rx.frame_len, 0);
    chk({tag, "_frame_active"}, rx.frame_active, 0);
    chk({tag, "_err"}, rx.err, 0);
  endtask

  initial begin
    int widths[24];
    m_reset();
    reset = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    m_reset();

    // 1: single fixed-timing pixel
    drive_low(GAP);
    send_pixel_fixed(24'hA5C30F);
    chk("t1_active", rx.frame_active, 1);
    drive_low(GAP);
    compare_all("t1");
    chk("t1_inactive", rx.frame_active, 0);

    // 2: multi-pixel frame, then a one-pixel frame
    send_pixel(24'h000000);
    send_pixel(24'hFFFFFF);
    send_pixel(24'h123456);
    drive_low(GAP);
    send_pixel(24'hABCDEF);
    drive_low(GAP);
    compare_all("t2");

    // 3: bits straight after reset are ignored until a gap
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();
    send_pixel(24'($urandom));
    send_pixel(24'($urandom));
    drive_low(GAP);
    send_pixel(24'($urandom));
    drive_low(GAP);
    compare_all("t3");

    // 4: glitch in the middle of pixel 1
    send_pixel(24'($urandom));
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    chk("t4_active_before", rx.frame_active, 1);
    drive_high(2);
    drive_low(10);
    chk("t4_active_after", rx.frame_active, 0);
    for (int i = 0; i < 13; i++) send_bit(1'($urandom));
    drive_low(GAP);
    send_pixel(24'($urandom));
    drive_low(GAP);
    compare_all("t4");

    // 5: partial pixel ended by a gap
    for (int i = 0; i < 12; i++) send_bit(1'($urandom));
    drive_low(GAP);
    compare_all("t5");

    // 6a: threshold and legal-width boundaries inside one pixel
    widths[0] = 25; widths[1] = 26; widths[2] = 4; widths[3] = 50;
    for (int i = 4; i < 24; i++) widths[i] = int'($urandom_range(T_MIN_HIGH, T_MAX_HIGH));
    for (int i = 0; i < 24; i++) begin
      drive_high(widths[i]);
      drive_low(int'($urandom_range(4, 30)));
    end
    drive_low(GAP);
    chk("t6_boundary_bits", m_word[23:20], 4'b0101);
    compare_all("t6a");

    // 6b: widths just outside the legal window
    send_pixel(24'($urandom));
    drive_high(3);
    drive_low(GAP);
    send_pixel(24'($urandom));
    drive_high(51);
    drive_low(GAP);
    compare_all("t6b");

    // 6c: reset after 10 bits of the second pixel
    send_pixel(24'($urandom));
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("t6c_reset");
    reset = 1'b0;
    m_reset();
    drive_low(GAP);
    send_pixel(24'($urandom));
    drive_low(GAP);
    compare_all("t6c");

    chk("pv_fd_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ws2812_receiver.md
Name: ws2812_receiver

Overview:
Decodes a WS2812 single-wire serial stream, as produced by the team's LED driver, back into 24-bit pixel words. It times each high pulse to classify it as a 0 or 1 bit and assembles the bits MSB-first into pixels. It detects the low-time reset gap that ends a frame and flags malformed pulses. It is used for loopback self-test of the LED output path and for daisy-chain monitoring, and runs on the 50 MHz system clock.

Parameters:
T_THRESH, 26, high-time in clk cycles at or above which a bit decodes as 1; below it decodes as 0.
T_MIN_HIGH, 4, shortest legal high pulse in cycles; anything shorter is a glitch error.
T_MAX_HIGH, 50, longest legal high pulse in cycles; anything longer is an error.
T_RESET, 2500, continuous low cycles that constitute a frame reset gap (50 us).
IDX_W, 16, width of the pixel index and frame length outputs.

Ports:
clk  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-high.
din  in  1  asynchronous serial WS2812 input.
pixel_data  out  24  last completed pixel; first received bit is in [23].
pixel_valid  out  1  one-cycle pulse when pixel_data updates.
pixel_idx  out  IDX_W  index of the pixel on pixel_data, 0-based within the frame.
frame_done  out  1  one-cycle pulse on the reset gap that ends a frame.
frame_len  out  IDX_W  complete pixels in the frame; valid while frame_done is high.
frame_active  out  1  high from the first rising edge after sync until frame_done or an error.
err  out  1  one-cycle pulse on a decode error.

Behaviour:
- Input path: din passes through a 2-flop synchronizer (flops reset to 0), giving din_s.
  - Edges are detected by comparing din_s with its registered copy.
  - Widths are counted in cycles that din_s is high or low.
- Reset: all outputs go to 0 on the clock after reset is sampled high.
  - The FSM enters SYNC and all counters, the shift register, bit count and pixel count clear.
  - Reset mid-pixel discards the partial pixel; no pixel_valid, frame_done or err is generated for it.
- FSM states are SYNC, LOW and HIGH.
- SYNC: counts consecutive low cycles; a rising edge clears the count.
  - When the count reaches T_RESET, move to LOW with no frame_done.
  - Highs seen in SYNC are never decoded.
- LOW: a rising edge moves to HIGH, clears the high counter and sets frame_active.
  - The low counter saturates at T_RESET.
  - On reaching T_RESET, if any bit was received since the last sync or gap:
    - pulse frame_done with frame_len equal to the pixel count;
    - if the bit count is nonzero, also pulse err in the same cycle and discard the partial pixel;
    - clear the pixel and bit counts and drop frame_active.
  - Only one frame_done is generated per gap.
- HIGH: the high counter saturates at T_MAX_HIGH+1.
  - On a falling edge with measured width h:
    - h < T_MIN_HIGH or h > T_MAX_HIGH: pulse err, discard the partial pixel, clear the pixel count, drop frame_active and go to SYNC. No frame_done is generated.
    - otherwise shift in bit = (h >= T_THRESH), increment the bit count, and go to LOW with the low counter cleared.
- Pixel completion: on the 24th bit, on the cycle following the falling edge:
  - pixel_data takes the word, pixel_valid pulses and pixel_idx takes the current pixel count;
  - then the pixel count increments (wraps modulo 2^IDX_W) and the bit count clears.
- Latency: pixel_valid is high exactly 4 clk cycles after the first clk edge that samples din low at the end of the 24th bit (2 sync + edge detect + register).
- Measured h equals the number of clk edges that sampled din high.
- Low time between bits is unconstrained below T_RESET.
- pixel_valid and frame_done can never coincide: frame_done needs T_RESET low cycles after the last edge.
- err and frame_done coincide only for the partial-pixel case.
- pixel_data and pixel_idx hold their values between pulses.

Test Plan:
1. Reset, din low 2500 cycles, pixel 0xA5C30F (highs 17/35, 64-cycle period), low 2500 -> one pixel_valid with data 0xA5C30F, idx 0, 4 cycles after the 24th fall; one frame_done with frame_len=1; err never high.
2. Pixels 0x000000, 0xFFFFFF, 0x123456, gap, then 0xABCDEF, gap -> idx 0,1,2 then frame_done len 3; next frame idx 0, frame_done len 1.
3. Bits sent immediately after reset with no initial 2500-cycle low -> no pixel_valid or err until a gap is seen; the following frame decodes correctly.
4. A 2-cycle high in the middle of pixel 1 -> err pulse, no pixel_valid for pixel 1, frame_active drops, no frame_done; after the gap the next frame decodes.
5. Twelve bits then a gap -> err and frame_done in the same cycle, frame_len=0.
6. Thresholds and mid-pixel reset:
   - high 25 -> 0, high 26 -> 1, high 4 and 50 legal, high 3 and 51 -> err;
   - reset asserted after 10 bits -> all outputs 0 next cycle, no pixel_valid.
